// File: rtl/db15_joy_tx.sv
// DB15 joystick link transmitter: answers host JOY_LOAD/JOY_CLK with two serialized player words.
// Optional watchdog abandons a stalled frame when DB15TX_WATCHDOG_EN is defined.
module db15_joy_tx #(
  parameter int BITS_PER_PLAYER = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int WDOG_CYCLES     = 4096
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [BITS_PER_PLAYER-1:0] joy1_in,
  input  logic [BITS_PER_PLAYER-1:0] joy2_in,
  input  logic                       joy_clk,
  input  logic                       joy_load,
  output logic                       joy_data,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [5:0]                 bit_idx
);

  localparam int         FRAME    = 2 * BITS_PER_PLAYER;
  localparam logic [5:0] LAST_IDX = 6'(FRAME);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] clkSync_q, loadSync_q;
  logic                   clkPrev_q, loadPrev_q;
  logic                   clkRise_q, loadFall_q, loadRise_q;
  logic                   clkRise_d, loadFall_d, loadRise_d;

  state_t             state_q;
  logic [FRAME-1:0]   sreg_q;
  logic [FRAME-1:0]   loadWord;
  logic               busy_q, done_q, ovr_q;
  logic [5:0]         idx_q;

  assign loadWord   = {~joy2_in, ~joy1_in};
  assign clkRise_d  =  clkSync_q[SYNC_STAGES-1] & ~clkPrev_q;
  assign loadRise_d =  loadSync_q[SYNC_STAGES-1] & ~loadPrev_q;
  assign loadFall_d = ~loadSync_q[SYNC_STAGES-1] &  loadPrev_q;

  // Synchronizers and edge detectors preset high so reset never looks like a host edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clkSync_q  <= '1;
      loadSync_q <= '1;
      clkPrev_q  <= 1'b1;
      loadPrev_q <= 1'b1;
      clkRise_q  <= 1'b0;
      loadFall_q <= 1'b0;
      loadRise_q <= 1'b0;
    end else begin
      clkSync_q  <= {clkSync_q[SYNC_STAGES-2:0], joy_clk};
      loadSync_q <= {loadSync_q[SYNC_STAGES-2:0], joy_load};
      clkPrev_q  <= clkSync_q[SYNC_STAGES-1];
      loadPrev_q <= loadSync_q[SYNC_STAGES-1];
      clkRise_q  <= clkRise_d;
      loadFall_q <= loadFall_d;
      loadRise_q <= loadRise_d;
    end
  end

`ifdef DB15TX_WATCHDOG_EN
  localparam int WW = (WDOG_CYCLES > 2) ? $clog2(WDOG_CYCLES) : 1;
  logic [WW-1:0] wdog_q;
`endif

  // joy_data is the shift register LSB, so idle/done states keep the register all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      idx_q   <= 6'd0;
`ifdef DB15TX_WATCHDOG_EN
      wdog_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          idx_q  <= 6'd0;
          if (loadFall_q) begin
            state_q <= LOAD;
            sreg_q  <= loadWord;
          end
        end
        LOAD: begin
          if (loadRise_q) begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
            idx_q   <= 6'd0;
`ifdef DB15TX_WATCHDOG_EN
            wdog_q  <= '0;
`endif
          end else begin
            sreg_q <= loadWord;
          end
        end
        SHIFT: begin
          if (loadFall_q) begin
            state_q <= LOAD;
            sreg_q  <= loadWord;
            busy_q  <= 1'b0;
            idx_q   <= 6'd0;
            ovr_q   <= 1'b1;
          end else if (clkRise_q) begin
            sreg_q <= {1'b1, sreg_q[FRAME-1:1]};
            idx_q  <= idx_q + 6'd1;
`ifdef DB15TX_WATCHDOG_EN
            wdog_q <= '0;
`endif
            if (idx_q + 6'd1 == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
`ifdef DB15TX_WATCHDOG_EN
          else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
            state_q <= IDLE;
            sreg_q  <= '1;
            busy_q  <= 1'b0;
            idx_q   <= 6'd0;
            ovr_q   <= 1'b1;
          end else begin
            wdog_q <= wdog_q + WW'(1);
          end
`endif
        end
        DONE: begin
          busy_q <= 1'b0;
          if (loadFall_q) begin
            state_q <= LOAD;
            sreg_q  <= loadWord;
            idx_q   <= 6'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign joy_data   = sreg_q[0];
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign bit_idx    = idx_q;

endmodule

// File: tb/tb_db15_joy_tx.sv
// Bench for db15_joy_tx: host-level model of the serial frame checked every settled cycle.
`timescale 1ns/1ps
module tb_db15_joy_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] joy1_in = 16'h0000;
  logic [15:0] joy2_in = 16'h0000;
  logic        joy_clk = 1'b1;
  logic        joy_load = 1'b1;
  logic        joy_data, busy, frame_done, overrun;
  logic [5:0]  bit_idx;

  always #10 clk = ~clk;

  db15_joy_tx #(
    .BITS_PER_PLAYER(16),
    .SYNC_STAGES(2),
    .WDOG_CYCLES(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .joy1_in(joy1_in),
    .joy2_in(joy2_in),
    .joy_clk(joy_clk),
    .joy_load(joy_load),
    .joy_data(joy_data),
    .busy(busy),
    .frame_done(frame_done),
    .overrun(overrun),
    .bit_idx(bit_idx)
  );

  int tests = 0;
  int fails = 0;
  int doneCnt = 0;
  int ovrCnt = 0;
  int expDone = 0;
  int expOvr = 0;

  // Host view: phase 0 = idle, 1 = load held low, 2 = frame released; mIdx = bits clocked.
  int          mPhase = 0;
  int          mIdx = 0;
  logic [15:0] mJ1 = 16'h0000;
  logic [15:0] mJ2 = 16'h0000;
  logic [31:0] cap = 32'h0;
  bit          checkEn = 1'b0;

  function automatic logic expBit(int n);
    if (n < 16)      return !mJ1[n];
    else if (n < 32) return !mJ2[n-16];
    else             return 1'b1;
  endfunction

  function automatic logic expData();
    if (mPhase == 1)      return !joy1_in[0];
    else if (mPhase == 2) return expBit(mIdx);
    else                  return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done === 1'b1) doneCnt++;
    if (overrun === 1'b1) ovrCnt++;
    if (checkEn) begin
      checkOutput("joy_data", 32'(joy_data), 32'(expData()));
      checkOutput("busy", 32'(busy), 32'((mPhase == 2) && (mIdx < 32)));
      checkOutput("bit_idx", 32'(bit_idx), (mPhase == 2) ? 32'(mIdx) : 32'd0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic releaseLoad();
    checkEn = 1'b0;
    mJ1 = joy1_in;
    mJ2 = joy2_in;
    joy_load = 1'b1;
    tick(6);
    mPhase = 2;
    mIdx = 0;
    cap[0] = joy_data;
    checkEn = 1'b1;
  endtask

  task automatic hostLoad(input int lowCycles);
    checkEn = 1'b0;
    if (mPhase == 2 && mIdx < 32) expOvr++;
    joy_load = 1'b0;
    tick(6);
    mPhase = 1;
    mIdx = 0;
    checkEn = 1'b1;
    tick(lowCycles - 6);
    releaseLoad();
  endtask

  task automatic hostClk();
    joy_clk = 1'b0;
    tick(10);
    checkEn = 1'b0;
    joy_clk = 1'b1;
    tick(6);
    if (mPhase == 2 && mIdx < 32) begin
      mIdx++;
      if (mIdx == 32) expDone++;
      else cap[mIdx] = joy_data;
    end
    checkEn = 1'b1;
    tick(4);
  endtask

  task automatic applyReset();
    checkEn = 1'b0;
    reset = 1'b1;
    tick(1);
    checkOutput("reset joy_data", 32'(joy_data), 32'd1);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset bit_idx", 32'(bit_idx), 32'd0);
    checkOutput("reset frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    mPhase = 0;
    mIdx = 0;
    checkEn = 1'b1;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, " frame_done count"}, 32'(doneCnt), 32'(expDone));
    checkOutput({tag, " overrun count"}, 32'(ovrCnt), 32'(expOvr));
  endtask

  task automatic applyStimulus();
    int n;
    tick(3);
    applyReset();
    tick(10);
    checkCounts("post-reset");

    // Basic frame
    joy1_in = 16'h0011;
    joy2_in = 16'h8000;
    hostLoad(10);
    checkOutput("first bit literal", 32'(joy_data), 32'd0);
    repeat (32) hostClk();
    checkOutput("stream literal", cap, 32'h7FFF_FFEE);
    checkOutput("final bit_idx literal", 32'(bit_idx), 32'd32);
    checkOutput("final busy literal", 32'(busy), 32'd0);
    checkCounts("basic");

    // Clock past end, with inputs changing in flight
    joy1_in = 16'hA5C3;
    joy2_in = 16'h0F0F;
    hostLoad(10);
    repeat (3) hostClk();
    joy1_in = 16'hFFFF;
    joy2_in = 16'hFFFF;
    repeat (33) hostClk();
    checkOutput("past-end bit_idx literal", 32'(bit_idx), 32'd32);
    checkCounts("past-end");

    // Mid-frame reload
    joy1_in = 16'h00A5;
    joy2_in = 16'h1234;
    hostLoad(10);
    repeat (10) hostClk();
    joy1_in = 16'h5A0E;
    joy2_in = 16'hC003;
    hostLoad(10);
    repeat (32) hostClk();
    checkCounts("reload");

    // Simultaneous clock rise and load fall
    joy1_in = 16'h0002;
    joy2_in = 16'h4001;
    hostLoad(10);
    repeat (4) hostClk();
    joy_clk = 1'b0;
    tick(10);
    checkEn = 1'b0;
    joy_clk = 1'b1;
    joy_load = 1'b0;
    expOvr++;
    tick(6);
    mPhase = 1;
    mIdx = 0;
    checkEn = 1'b1;
    tick(4);
    releaseLoad();
    checkOutput("simul bit_idx literal", 32'(bit_idx), 32'd0);
    repeat (32) hostClk();
    checkCounts("simul");

    // Reset at bit 17
    joy1_in = 16'h1357;
    joy2_in = 16'h2468;
    hostLoad(10);
    repeat (17) hostClk();
    checkOutput("bit_idx before reset", 32'(bit_idx), 32'd17);
    applyReset();
    tick(20);
    repeat (2) hostClk();
    checkCounts("mid-reset");

    // Stalled host clock
    joy1_in = 16'h0F00;
    joy2_in = 16'h00F0;
    hostLoad(10);
    repeat (5) hostClk();
`ifdef DB15TX_WATCHDOG_EN
    checkEn = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    expOvr++;
    checkOutput("wdog busy", 32'(busy), 32'd0);
    checkOutput("wdog latency in window", 32'((n >= 50) && (n <= 64)), 32'd1);
    mPhase = 0;
    mIdx = 0;
    tick(5);
    checkOutput("wdog joy_data", 32'(joy_data), 32'd1);
    checkOutput("wdog bit_idx", 32'(bit_idx), 32'd0);
    checkEn = 1'b1;
    tick(5);
`else
    n = 1000;
    tick(n);
    checkOutput("no-wdog busy literal", 32'(busy), 32'd1);
`endif
    checkCounts("stall");
  endtask

  initial begin
    applyStimulus();
    checkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
